div_mod_unit: RTL and testbench

DIV_MOD_UNIT -- requirements
Module: div_mod_unit

---
 rtl/div_mod_pkg.sv | 15 +
 rtl/div_step.sv | 24 ++
 rtl/div_mod_unit.sv | 114 +++++++++++
 tb/tb_div_mod_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/div_mod_pkg.sv
// rtl/div_mod_pkg.sv - shared width, state type and divide-by-zero constant for the divider
package div_mod_pkg;

   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Quotient reported when the divisor is zero
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             qbit_o
);

   // Two extra bits: one for the shifted-in dividend bit, one to expose the borrow
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {2'b00, divisor_i};

   // The partial remainder is always below the divisor, so the shifted value fits in
   // WIDTH+1 bits and the top bit of the difference is a clean borrow flag
   assign qbit_o = ~diff[WIDTH+1];
   assign rem_o  = qbit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_mod_unit.sv
// rtl/div_mod_unit.sv - multi-cycle unsigned restoring divider returning quotient and remainder
module div_mod_unit
   import div_mod_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] inputA,
   input  logic [WIDTH-1:0] inputB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             error
);

   localparam int                CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB, so after
   // WIDTH steps this register holds the quotient
   logic [WIDTH-1:0] aq_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   rem_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;

   logic [WIDTH:0]   rem_d;
   logic             qbit_d;
   logic [WIDTH-1:0] aq_d;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .bit_i     (aq_q[WIDTH-1]),
      .divisor_i (b_q),
      .rem_o     (rem_d),
      .qbit_o    (qbit_d)
   );

   assign aq_d = {aq_q[WIDTH-2:0], qbit_d};

   // Control FSM plus datapath registers; all outputs come straight from flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         aq_q        <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  aq_q   <= inputA;
                  b_q    <= inputB;
                  rem_q  <= '0;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (inputB == '0) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     quotient_q  <= DIV0_QUOTIENT;
                     remainder_q <= inputA;
                     error_q     <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               aq_q  <= aq_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  quotient_q  <= aq_d;
                  remainder_q <= rem_d[WIDTH-1:0];
                  error_q     <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_div_mod_unit.sv
// tb/tb_div_mod_unit.sv - directed self-checking bench for div_mod_unit
module tb_div_mod_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] inputA = '0;
   logic [15:0] inputB = '0;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] quotient;
   logic [15:0] remainder;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_mod_unit #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .inputA    (inputA),
      .inputB    (inputB),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .error     (error)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        err;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Issue one start pulse, then wait (bounded) for done; counts cycles after the start edge
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat, output int bcnt);
      @(negedge clk);
      inputA = a;
      inputB = b;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      bcnt  = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (busy) bcnt++;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_error"}, 32'(error), 0);
      check({tag, "_quotient"}, 32'(quotient), 0);
      check({tag, "_remainder"}, 32'(remainder), 0);
   endtask

   initial begin
      int  lat;
      int  bcnt;
      int  k;
      bit  saw_done;

      vecs[0]  = '{16'd249,   16'd69,    16'd3,     16'd42,    1'b0};
      vecs[1]  = '{16'd32000, 16'd16001, 16'd1,     16'd15999, 1'b0};
      vecs[2]  = '{16'd1234,  16'd0,     16'd65535, 16'd1234,  1'b1};
      vecs[3]  = '{16'd65535, 16'd1,     16'd65535, 16'd0,     1'b0};
      vecs[4]  = '{16'd5,     16'd65535, 16'd0,     16'd5,     1'b0};
      vecs[5]  = '{16'd65535, 16'd32768, 16'd1,     16'd32767, 1'b0};
      vecs[6]  = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
      vecs[7]  = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
      vecs[8]  = '{16'd65535, 16'd65535, 16'd1,     16'd0,     1'b0};
      vecs[9]  = '{16'd1000,  16'd33,    16'd30,    16'd10,    1'b0};
      vecs[10] = '{16'd40000, 16'd300,   16'd133,   16'd100,   1'b0};

      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         int exp_lat;
         exp_lat = (vecs[i].b == 16'd0) ? 1 : 17;
         run_op(vecs[i].a, vecs[i].b, lat, bcnt);
         check($sformatf("v%0d_done", i), 32'(done), 1);
         check($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
         check($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
         check($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].err));
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
         check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(exp_lat));
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), 32'(done), 0);
         check($sformatf("v%0d_idle_busy", i), 32'(busy), 0);
         check($sformatf("v%0d_hold_quotient", i), 32'(quotient), 32'(vecs[i].q));
      end

      // Start pulse with different operands at RUN cycle 5 must be ignored
      @(negedge clk);
      inputA = 16'd249;
      inputB = 16'd69;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (!done && k < 40) begin
         if (k == 5) begin
            inputA = 16'd1000;
            inputB = 16'd33;
            start  = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("ignore_latency", 32'(k), 17);
      check("ignore_quotient", 32'(quotient), 3);
      check("ignore_remainder", 32'(remainder), 42);
      @(negedge clk);
      @(negedge clk);
      check("ignore_no_restart", 32'(busy), 0);

      // Start held high: second op accepted in the first IDLE cycle; operand change mid-op is invisible
      inputA = 16'd100;
      inputB = 16'd7;
      start  = 1'b1;
      @(negedge clk);
      inputA = 16'd65535;
      inputB = 16'd1;
      k = 1;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("hold_first_latency", 32'(k), 17);
      check("hold_first_quotient", 32'(quotient), 14);
      check("hold_first_remainder", 32'(remainder), 2);
      @(negedge clk);
      check("hold_idle_cycle_busy", 32'(busy), 0);
      @(negedge clk);
      check("hold_second_accepted", 32'(busy), 1);
      start = 1'b0;
      k = 2;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("hold_period", 32'(k), 18);
      check("hold_second_quotient", 32'(quotient), 65535);
      check("hold_second_remainder", 32'(remainder), 0);

      // Reset during RUN cycle 8 after a divide-by-zero left nonzero outputs
      run_op(16'd1234, 16'd0, lat, bcnt);
      check("pre_reset_error", 32'(error), 1);
      @(negedge clk);
      inputA = 16'd249;
      inputB = 16'd69;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (k < 8) begin
         @(negedge clk);
         k++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_zero_outputs("midrun_reset");
      saw_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("midrun_no_done", 32'(saw_done), 0);
      run_op(16'd100, 16'd7, lat, bcnt);
      check("post_reset_quotient", 32'(quotient), 14);
      check("post_reset_remainder", 32'(remainder), 2);
      check("post_reset_latency", 32'(lat), 17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
